// File: rtl/md_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide unit.
package md_pkg;

    localparam int DIV_ITERS = 32;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_md_arith(input logic [2:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, MSB first.
module div_radix2
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [4:0]  count;
    logic [31:0] divisor_q;
    logic [32:0] partial;
    logic [32:0] trial;

    // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
    assign partial = {remainder, quotient[31]};
    assign trial   = partial - {1'b0, divisor_q};
    // done marks the cycle whose closing edge retires the final iteration
    assign done    = busy && (count == 5'(DIV_ITERS - 1));

    // NOTE: reset is sampled on the clock edge and every register is cleared explicitly.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy      <= 1'b0;
            count     <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            count     <= '0;
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            if (!trial[32]) begin
                remainder <= trial[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= partial[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            count <= count + 5'd1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: stalls until the result is ready, commits HI/LO when EX retires.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [2:0]    ex_md_op,
    input  logic [DW-1:0] ex_rs_val,
    input  logic [DW-1:0] ex_rt_val,
    input  logic          ex_ec_stall,
    input  logic          exc_oc,
    output logic          div_mul_stall,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    logic [1:0]  state;
    logic [2:0]  count;
    logic        op_is_div;
    logic        op_signed;
    logic        rem_neg;
    logic        quo_neg;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] result;
    logic [63:0] product;
    logic [63:0] commit_val;

    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic ex_is_div;
    logic ex_signed;

    assign ex_is_div = (ex_md_op == MD_DIV) || (ex_md_op == MD_DIVU);
    assign ex_signed = (ex_md_op == MD_DIV) || (ex_md_op == MD_MULT);
    assign div_start = (state == ST_IDLE) && ex_is_div && !exc_oc;

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (exc_oc),
        .dividend  (abs32(ex_rs_val, ex_signed)),
        .divisor   (abs32(ex_rt_val, ex_signed)),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign product = {{32{op_signed & mul_a[31]}}, mul_a} * {{32{op_signed & mul_b[31]}}, mul_b};

    assign commit_val = op_is_div ? {(rem_neg ? -div_rem : div_rem), (quo_neg ? -div_quo : div_quo)}
                                  : result;

    always_comb begin
        div_mul_stall = 1'b0;
        if (!exc_oc) begin
            case (state)
                ST_IDLE: div_mul_stall = is_md_arith(ex_md_op);
                ST_MUL,
                ST_DIV:  div_mul_stall = 1'b1;
                default: div_mul_stall = 1'b0;
            endcase
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            count     <= '0;
            op_is_div <= 1'b0;
            op_signed <= 1'b0;
            rem_neg   <= 1'b0;
            quo_neg   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
        end else if (exc_oc) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_md_arith(ex_md_op)) begin
                        op_is_div <= ex_is_div;
                        op_signed <= ex_signed;
                        rem_neg   <= ex_signed & ex_rs_val[31];
                        quo_neg   <= ex_signed & (ex_rs_val[31] ^ ex_rt_val[31]);
                        mul_a     <= ex_rs_val;
                        mul_b     <= ex_rt_val;
                        count     <= '0;
                        state     <= ex_is_div ? ST_DIV : ST_MUL;
                    end else if (!ex_ec_stall) begin
                        if (ex_md_op == MD_MTHI) hi <= ex_rs_val;
                        if (ex_md_op == MD_MTLO) lo <= ex_rs_val;
                    end
                end
                ST_MUL: begin
                    result <= product;
                    if (count == 3'(MUL_LAT - 1)) state <= ST_DONE;
                    else                          count <= count + 3'd1;
                end
                ST_DIV: begin
                    if (div_done) state <= ST_DONE;
                end
                default: begin
                    if (!ex_ec_stall) begin
                        {hi, lo} <= commit_val;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit with hand-written multi-cycle corner sequences.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  ex_md_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic        ex_ec_stall;
    logic        exc_oc;
    logic        div_mul_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          stall;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[12];

    md_unit #(.MUL_LAT(1), .DW(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ex_md_op      (ex_md_op),
        .ex_rs_val     (ex_rs_val),
        .ex_rt_val     (ex_rt_val),
        .ex_ec_stall   (ex_ec_stall),
        .exc_oc        (exc_oc),
        .div_mul_stall (div_mul_stall),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts stalled cycles (bounded); operands are scrambled after the capture edge.
    task automatic wait_stall_low(output int n);
        n = 0;
        #1;
        while (div_mul_stall && n <= 100) begin
            n++;
            @(posedge clk);
            #1;
            ex_rs_val = $urandom;
            ex_rt_val = $urandom;
            #1;
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        ex_md_op  = v.op;
        ex_rs_val = v.rs;
        ex_rt_val = v.rt;
        wait_stall_low(n);
        check({v.name, " stall_cycles"}, n, v.stall);
        check({v.name, " hi_before_commit"}, hi, cur_hi);
        check({v.name, " lo_before_commit"}, lo, cur_lo);
        @(posedge clk);
        #1;
        ex_md_op = MD_NONE;
        #1;
        check({v.name, " hi"}, hi, v.hi);
        check({v.name, " lo"}, lo, v.lo);
        cur_hi = v.hi;
        cur_lo = v.lo;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 2,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 2,  32'h00000002, 32'hFFFFFFFA, "multu_fffffffex3"};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"};
        vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        33, 32'd2,        32'd14,       "divu_100_7"};
        vecs[4]  = '{MD_DIVU,  32'd5,        32'd0,        33, 32'd5,        32'hFFFFFFFF, "divu_5_0"};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, "div_overflow"};
        vecs[6]  = '{MD_MULT,  32'd7,        32'hFFFFFFFB, 2,  32'hFFFFFFFF, 32'hFFFFFFDD, "mult_7xneg5"};
        vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        33, 32'hFFFFFFFB, 32'h00000001, "div_neg5_0"};
        vecs[9]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[10] = '{MD_MTHI,  32'h12345678, 32'h0,        0,  32'h12345678, 32'h00000001, "mthi"};
        vecs[11] = '{MD_MTLO,  32'h0000CAFE, 32'h0,        0,  32'h12345678, 32'h0000CAFE, "mtlo"};

        resetn      = 1'b0;
        ex_md_op    = MD_NONE;
        ex_rs_val   = '0;
        ex_rt_val   = '0;
        ex_ec_stall = 1'b0;
        exc_oc      = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset stall", div_mul_stall, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        resetn = 1'b1;
        tick();

        // Back-to-back: each vector is issued in the cycle right after the previous commit.
        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // DONE held by downstream stall for 4 cycles, then commit.
        ex_ec_stall = 1'b1;
        ex_md_op    = MD_DIVU;
        ex_rs_val   = 32'd100;
        ex_rt_val   = 32'd7;
        wait_stall_low(n);
        check("hold stall_cycles", n, 33);
        for (int i = 0; i < 4; i++) begin
            check("hold stall_in_done", div_mul_stall, 0);
            check("hold hi_unchanged", hi, cur_hi);
            check("hold lo_unchanged", lo, cur_lo);
            tick();
        end
        ex_ec_stall = 1'b0;
        @(posedge clk);
        #1;
        ex_md_op = MD_NONE;
        #1;
        check("hold hi_commit", hi, 32'd2);
        check("hold lo_commit", lo, 32'd14);
        cur_hi = 32'd2;
        cur_lo = 32'd14;

        // Exception flush at DIV iteration 10.
        ex_md_op  = MD_DIV;
        ex_rs_val = 32'hFFFFFFF9;
        ex_rt_val = 32'd2;
        #2;
        for (int i = 0; i < 11; i++) tick();
        check("exc stall_before", div_mul_stall, 1);
        exc_oc = 1'b1;
        #1;
        check("exc stall_same_cycle", div_mul_stall, 0);
        @(posedge clk);
        #1;
        exc_oc   = 1'b0;
        ex_md_op = MD_NONE;
        #1;
        check("exc stall_after", div_mul_stall, 0);
        check("exc hi_unchanged", hi, cur_hi);
        check("exc lo_unchanged", lo, cur_lo);
        run_op(vecs[6]);

        // Reset in the middle of a division.
        ex_md_op  = MD_DIV;
        ex_rs_val = 32'hFFFFFFF9;
        ex_rt_val = 32'd2;
        #2;
        repeat (6) tick();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        ex_md_op = MD_NONE;
        #1;
        check("rst_mid stall", div_mul_stall, 0);
        check("rst_mid hi", hi, 0);
        check("rst_mid lo", lo, 0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        run_op(vecs[4]);

        // MTLO waits out a 2-cycle downstream stall.
        ex_ec_stall = 1'b1;
        ex_md_op    = MD_MTLO;
        ex_rs_val   = 32'h00001234;
        #2;
        for (int i = 0; i < 2; i++) begin
            check("mtlo stall_out", div_mul_stall, 0);
            tick();
            check("mtlo lo_held", lo, cur_lo);
        end
        ex_ec_stall = 1'b0;
        @(posedge clk);
        #1;
        ex_md_op = MD_NONE;
        #1;
        check("mtlo lo_written", lo, 32'h00001234);
        cur_lo = 32'h00001234;

        // MTHI squashed by an exception.
        ex_md_op  = MD_MTHI;
        ex_rs_val = 32'hDEADBEEF;
        exc_oc    = 1'b1;
        @(posedge clk);
        #1;
        ex_md_op = MD_NONE;
        exc_oc   = 1'b0;
        #1;
        check("mthi_exc hi_unchanged", hi, cur_hi);

        // Exception in DONE overrides the commit.
        ex_ec_stall = 1'b1;
        ex_md_op    = MD_MULT;
        ex_rs_val   = 32'hFFFFFFFE;
        ex_rt_val   = 32'd3;
        wait_stall_low(n);
        check("done_exc stall_cycles", n, 2);
        ex_ec_stall = 1'b0;
        exc_oc      = 1'b1;
        @(posedge clk);
        #1;
        exc_oc   = 1'b0;
        ex_md_op = MD_NONE;
        #1;
        check("done_exc hi_unchanged", hi, cur_hi);
        check("done_exc lo_unchanged", lo, cur_lo);
        check("done_exc stall_after", div_mul_stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
